karatsuba_seq_ctrl: RTL

Multi-cycle 2N-bit product engine built around one shared combinational karatsuba multiplier of width N/2.
- Computes X*Y in three sequenced half-width multiplies: lo=x0*y0, hi=x1*y1, mid=(x0+x1)*(y0+y1).
- Combines them as Z = hi<<N + (mid-lo-hi)<<(N/2) + lo.
- Replaces the fully unrolled karatsuba_16 where area matters more than throughput.
- Valid/ready handshake on both input and output sides.

---
 rtl/karatsuba_seq_ctrl_pkg.sv | 28 ++
 rtl/karatsuba_seq_ctrl_arith.sv | 27 ++
 rtl/karatsuba_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/karatsuba_seq_ctrl_pkg.sv
// Shared definitions for the sequential karatsuba product engine:
// FSM state encoding and width helpers derived from the operand width.
package karatsuba_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LO   = 3'd1,
      HI   = 3'd2,
      MID  = 3'd3,
      CMB  = 3'd4,
      DONE = 3'd5
   } state_e;

   localparam int unsigned N_DEFAULT = 16;

   function automatic int unsigned half_w(input int unsigned n);
      return n / 2;
   endfunction

   function automatic int unsigned p_mid_w(input int unsigned n);
      return n + 2;
   endfunction

   function automatic int unsigned m_term_w(input int unsigned n);
      return n + 1;
   endfunction

endpackage

// File: rtl/karatsuba_seq_ctrl_arith.sv
// Arithmetic building blocks shared across the codebase: the combinational
// N x N multiplier and a plain WIDTH-bit adder.
module karatsuba #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   localparam int unsigned PW = 2 * N;

   assign p = PW'(a) * PW'(b);

endmodule

module adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s
);

   assign s = a + b;

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Multi-cycle 2N-bit multiplier: three half-width products through one shared
// karatsuba instance (lo, hi, mid), combined in CMB, held in DONE until taken.
module karatsuba_seq_ctrl
   import karatsuba_seq_ctrl_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   X,
   input  logic [N-1:0]   Y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] Z,
   output logic           busy
);

   localparam int unsigned H        = half_w(N);
   localparam int unsigned P_MID_W  = p_mid_w(N);
   localparam int unsigned M_TERM_W = m_term_w(N);
   localparam int unsigned Z_W      = 2 * N;

   state_e               state_q, state_d;
   logic [N-1:0]         xr_q, xr_d;
   logic [N-1:0]         yr_q, yr_d;
   logic [N-1:0]         p_lo_q, p_lo_d;
   logic [N-1:0]         p_hi_q, p_hi_d;
   logic [P_MID_W-1:0]   p_mid_q, p_mid_d;
   logic [Z_W-1:0]       z_q, z_d;

   logic [H-1:0]         mul_a, mul_b;
   logic [N-1:0]         mul_p;
   logic [H:0]           sx, sy;
   logic [P_MID_W-1:0]   mid_corr;
   logic [M_TERM_W:0]    mterm_ext;
   logic [Z_W-1:0]       z_mid, z_sum;

   assign sx = {1'b0, xr_q[H-1:0]} + {1'b0, xr_q[N-1:H]};
   assign sy = {1'b0, yr_q[H-1:0]} + {1'b0, yr_q[N-1:H]};

   always_comb begin
      mul_a = xr_q[H-1:0];
      mul_b = yr_q[H-1:0];
      case (state_q)
         HI: begin
            mul_a = xr_q[N-1:H];
            mul_b = yr_q[N-1:H];
         end
         MID: begin
            mul_a = sx[H-1:0];
            mul_b = sy[H-1:0];
         end
         default: ;
      endcase
   end

   karatsuba #(.N(H)) u_mul (
      .a (mul_a),
      .b (mul_b),
      .p (mul_p)
   );

   // Restore the carry bits of sx/sy that the half-width multiplier cannot see.
   always_comb begin
      mid_corr = P_MID_W'(mul_p);
      if (sx[H]) mid_corr = mid_corr + P_MID_W'({sy[H-1:0], {H{1'b0}}});
      if (sy[H]) mid_corr = mid_corr + P_MID_W'({sx[H-1:0], {H{1'b0}}});
      if (sx[H] & sy[H]) mid_corr = mid_corr + {2'b01, {N{1'b0}}};
   end

   // One guard bit above the N+1-bit middle term; it stays zero whenever
   // p_mid >= p_lo + p_hi, so a set guard bit flags an arithmetic wrap.
   assign mterm_ext = p_mid_q - P_MID_W'(p_lo_q) - P_MID_W'(p_hi_q);
   assign z_mid     = Z_W'({mterm_ext, {H{1'b0}}});

   adder #(.WIDTH(Z_W)) u_zadd (
      .a ({p_hi_q, p_lo_q}),
      .b (z_mid),
      .s (z_sum)
   );

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      p_lo_d  = p_lo_q;
      p_hi_d  = p_hi_q;
      p_mid_d = p_mid_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               xr_d    = X;
               yr_d    = Y;
               state_d = LO;
            end
         end
         LO: begin
            p_lo_d  = mul_p;
            state_d = HI;
         end
         HI: begin
            p_hi_d  = mul_p;
            state_d = MID;
         end
         MID: begin
            p_mid_d = mid_corr;
            state_d = CMB;
         end
         CMB: begin
            z_d     = z_sum;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         p_lo_q  <= '0;
         p_hi_q  <= '0;
         p_mid_q <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         p_lo_q  <= p_lo_d;
         p_hi_q  <= p_hi_d;
         p_mid_q <= p_mid_d;
         z_q     <= z_d;
      end
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign Z         = z_q;

endmodule
